// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC register, word-addressed imem, IF/ID pipeline register.
// Latency: instruction at fetch_pc=A appears on outputs one clock after; imem read is combinational.
// Backpressure: stall holds PC and IF/ID; do_branch overrides stall. Optional macro IFETCH_PERF_CNT_EN.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 do_branch,
    input  logic [31:0]          branch_addr,
    input  logic                 imem_we,
    input  logic [ADDR_BITS-1:0] imem_waddr,
    input  logic [31:0]          imem_wdata,
    output logic [31:0]          pc,
    output logic [31:0]          pc4,
    output logic [31:0]          instruction,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]          fetch_count,
    output logic [31:0]          squash_count,
`endif
    output logic                 inst_valid
);

    // Instruction storage; not reset so it can map onto a RAM macro.
    logic [31:0] imem [0:DEPTH-1];

    logic [31:0]          fetch_pc;
    logic [31:0]          fetch_pc_plus4;
    logic [31:0]          branch_target;
    logic [ADDR_BITS-1:0] read_index;
    logic [31:0]          fetch_word;

    // Redirect target is always word aligned; the dropped low bits are
    // intentionally ignored.
    logic unused_branch_low;
    assign unused_branch_low = ^branch_addr[1:0];

    // Combinational fetch path: index wraps modulo DEPTH, PC math modulo 2^32.
    always_comb begin
        read_index     = fetch_pc[ADDR_BITS+1:2];
        fetch_word     = imem[read_index];
        fetch_pc_plus4 = fetch_pc + 32'd4;
        branch_target  = {branch_addr[31:2], 2'b00};
    end

    // Program load port; a same-cycle fetch of the same word sees the old data.
    always_ff @(posedge clock) begin
        if (reset && imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // PC and IF/ID register: redirect squashes, stall holds, otherwise advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            pc          <= 32'd0;
            pc4         <= 32'd0;
            instruction <= 32'd0;
            inst_valid  <= 1'b0;
        end else if (do_branch) begin
            fetch_pc    <= branch_target;
            pc          <= fetch_pc;
            pc4         <= fetch_pc_plus4;
            instruction <= 32'd0;
            inst_valid  <= 1'b0;
        end else if (!stall) begin
            fetch_pc    <= fetch_pc_plus4;
            pc          <= fetch_pc;
            pc4         <= fetch_pc_plus4;
            instruction <= fetch_word;
            inst_valid  <= 1'b1;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Event counters: valid loads into IF/ID, and redirects (which count even
    // when they coincide with a stall).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count  <= 32'd0;
            squash_count <= 32'd0;
        end else if (do_branch) begin
            squash_count <= squash_count + 32'd1;
        end else if (!stall) begin
            fetch_count  <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
